branch_predictor: RTL and testbench

//  Dynamic branch predictor/BTB for the 5-stage MIPS pipeline; replaces static predict-not-taken.

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                direction counters. Lookup from IF is combinational. The
//                table is written at the clock edge from ID once the branch
//                is resolved. Saturating branch/mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_in,
  // IF-stage lookup
  input  logic [ADDR_W-1:0] lookup_pc_in,
  output logic              pred_hit_out,
  output logic              pred_taken_out,
  output logic [ADDR_W-1:0] pred_target_out,
  // ID-stage resolution
  input  logic              update_valid_in,
  input  logic [ADDR_W-1:0] update_pc_in,
  input  logic              update_taken_in,
  input  logic [ADDR_W-1:0] update_target_in,
  input  logic              update_mispredict_in,
  // statistics
  output logic [CNT_W-1:0]  branch_count_out,
  output logic [CNT_W-1:0]  mispredict_count_out
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int HI_LSB = IDX_W + TAG_W + 2;

  // Table storage
  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  // Index/tag fields; pc[1:0] is always word-aligned and carries no information
  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_up_hit;
  logic [1:0]        w_ctr_d;

  assign w_lk_idx = lookup_pc_in[IDX_W+1:2];
  assign w_lk_tag = lookup_pc_in[HI_LSB-1:IDX_W+2];
  assign w_up_idx = update_pc_in[IDX_W+1:2];
  assign w_up_tag = update_pc_in[HI_LSB-1:IDX_W+2];

  // Bits outside index/tag are intentionally not looked at
  logic w_unused_lo;
  assign w_unused_lo = ^{lookup_pc_in[1:0], update_pc_in[1:0]};

  generate
    if (HI_LSB < ADDR_W) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{lookup_pc_in[ADDR_W-1:HI_LSB], update_pc_in[ADDR_W-1:HI_LSB]};
    end
  endgenerate

  // Combinational lookup; reads the pre-update table (no write bypass)
  always_comb begin
    pred_hit_out    = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    pred_taken_out  = pred_hit_out && ctr_q[w_lk_idx][1];
    pred_target_out = pred_taken_out ? target_q[w_lk_idx] : lookup_pc_in + ADDR_W'(4);
  end

  // Hit detection and saturating counter step for the resolved branch
  always_comb begin
    w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);
    w_ctr_d  = ctr_q[w_up_idx];
    if (update_taken_in) begin
      if (ctr_q[w_up_idx] != 2'b11) w_ctr_d = ctr_q[w_up_idx] + 2'd1;
    end else begin
      if (ctr_q[w_up_idx] != 2'b00) w_ctr_d = ctr_q[w_up_idx] - 2'd1;
    end
  end

  // Table write: train on hit, allocate weakly-taken on taken miss; reset wins
  always_ff @(posedge clk) begin
    if (reset_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (update_valid_in) begin
      if (w_up_hit) begin
        ctr_q[w_up_idx] <= w_ctr_d;
        if (update_taken_in) target_q[w_up_idx] <= update_target_in;
      end else if (update_taken_in) begin
        valid_q[w_up_idx]  <= 1'b1;
        tag_q[w_up_idx]    <= w_up_tag;
        target_q[w_up_idx] <= update_target_in;
        ctr_q[w_up_idx]    <= 2'b10;
      end
    end
  end

  // Statistics next-state: count resolved branches and mispredicts, hold at all-ones
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update_valid_in) begin
      if (branch_cnt_q != {CNT_W{1'b1}}) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (update_mispredict_in && (mispred_cnt_q != {CNT_W{1'b1}}))
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset_in) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_count_out     = branch_cnt_q;
  assign mispredict_count_out = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed, table-driven bench for branch_predictor, plus
//                hand sequences for reset-during-update and counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lk_pc;
  logic        hit, taken;
  logic [31:0] tgt;
  logic        up_v, up_t, up_m;
  logic [31:0] up_pc, up_tgt;
  logic [15:0] bcnt, mcnt;

  // small-counter instance for saturation
  logic        s_up_v;
  logic        s_hit, s_taken;
  logic [31:0] s_tgt;
  logic [3:0]  s_bcnt, s_mcnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .TAG_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset_in(rst),
    .lookup_pc_in(lk_pc), .pred_hit_out(hit), .pred_taken_out(taken), .pred_target_out(tgt),
    .update_valid_in(up_v), .update_pc_in(up_pc), .update_taken_in(up_t),
    .update_target_in(up_tgt), .update_mispredict_in(up_m),
    .branch_count_out(bcnt), .mispredict_count_out(mcnt)
  );

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .TAG_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .reset_in(rst),
    .lookup_pc_in(32'h0040_0010), .pred_hit_out(s_hit), .pred_taken_out(s_taken),
    .pred_target_out(s_tgt),
    .update_valid_in(s_up_v), .update_pc_in(32'h0040_0010), .update_taken_in(1'b1),
    .update_target_in(32'h0040_0100), .update_mispredict_in(1'b1),
    .branch_count_out(s_bcnt), .mispredict_count_out(s_mcnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        t;
    logic [31:0] utgt;
    logic        m;
    logic [31:0] lpc;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic [15:0] e_b;
    logic [15:0] e_m;
  } vec_t;

  localparam logic [31:0] PA = 32'h0040_0010;  // idx 4, tag 0
  localparam logic [31:0] PB = 32'h0040_0050;  // idx 4, tag 1
  localparam logic [31:0] PC = 32'h0040_0020;  // idx 8
  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] TA2 = 32'h0040_0300;
  localparam logic [31:0] TB = 32'h0040_0200;

  vec_t vecs [20];

  initial begin
    // Outputs are checked before this row's update takes effect at the next edge.
    //          v     pc   t     utgt  m     lpc            hit   tkn   tgt     b   m
    vecs[0]  = '{1'b0, PA, 1'b0, TA,  1'b0, PA,            1'b0, 1'b0, PA+4,   0, 0};
    vecs[1]  = '{1'b1, PA, 1'b1, TA,  1'b1, PA,            1'b0, 1'b0, PA+4,   0, 0};
    vecs[2]  = '{1'b0, PA, 1'b0, TA,  1'b0, PA,            1'b1, 1'b1, TA,     1, 1};
    vecs[3]  = '{1'b1, PA, 1'b0, TA,  1'b1, PA,            1'b1, 1'b1, TA,     1, 1};
    vecs[4]  = '{1'b1, PA, 1'b0, TA,  1'b0, PA,            1'b1, 1'b0, PA+4,   2, 2};
    vecs[5]  = '{1'b1, PA, 1'b0, TA,  1'b0, PA,            1'b1, 1'b0, PA+4,   3, 2};
    vecs[6]  = '{1'b1, PA, 1'b1, TA2, 1'b1, PA,            1'b1, 1'b0, PA+4,   4, 2};
    vecs[7]  = '{1'b1, PA, 1'b1, TA2, 1'b1, PA,            1'b1, 1'b0, PA+4,   5, 3};
    vecs[8]  = '{1'b0, PA, 1'b0, TA,  1'b0, PA,            1'b1, 1'b1, TA2,    6, 4};
    vecs[9]  = '{1'b0, PA, 1'b0, TB,  1'b1, PA,            1'b1, 1'b1, TA2,    6, 4};
    vecs[10] = '{1'b1, PB, 1'b1, TB,  1'b1, PA,            1'b1, 1'b1, TA2,    6, 4};
    vecs[11] = '{1'b0, PA, 1'b0, TA,  1'b0, PA,            1'b0, 1'b0, PA+4,   7, 5};
    vecs[12] = '{1'b0, PA, 1'b0, TA,  1'b0, PB,            1'b1, 1'b1, TB,     7, 5};
    vecs[13] = '{1'b1, PC, 1'b0, TA,  1'b0, PC,            1'b0, 1'b0, PC+4,   7, 5};
    vecs[14] = '{1'b0, PC, 1'b0, TA,  1'b0, PC,            1'b0, 1'b0, PC+4,   8, 5};
    vecs[15] = '{1'b1, PB, 1'b1, TB,  1'b0, PB,            1'b1, 1'b1, TB,     8, 5};
    vecs[16] = '{1'b1, PB, 1'b1, TB,  1'b0, PB,            1'b1, 1'b1, TB,     9, 5};
    vecs[17] = '{1'b1, PB, 1'b0, TA,  1'b0, PB,            1'b1, 1'b1, TB,    10, 5};
    vecs[18] = '{1'b0, PB, 1'b0, TA,  1'b0, 32'h0040_0052, 1'b1, 1'b1, TB,    11, 5};
    vecs[19] = '{1'b0, PB, 1'b0, TA,  1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 11, 5};

    rst = 1'b1; up_v = 1'b0; up_pc = '0; up_t = 1'b0; up_tgt = '0; up_m = 1'b0;
    lk_pc = PA; s_up_v = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      up_v = vecs[i].v; up_pc = vecs[i].pc; up_t = vecs[i].t;
      up_tgt = vecs[i].utgt; up_m = vecs[i].m; lk_pc = vecs[i].lpc;
      @(negedge clk);
      check($sformatf("row%0d hit", i),    {31'b0, hit},   {31'b0, vecs[i].e_hit});
      check($sformatf("row%0d taken", i),  {31'b0, taken}, {31'b0, vecs[i].e_taken});
      check($sformatf("row%0d target", i), tgt,            vecs[i].e_tgt);
      check($sformatf("row%0d bcnt", i),   {16'b0, bcnt},  {16'b0, vecs[i].e_b});
      check($sformatf("row%0d mcnt", i),   {16'b0, mcnt},  {16'b0, vecs[i].e_m});
      @(posedge clk); #1;
    end
    up_v = 1'b0;

    // Reset asserted together with a taken update on PA: update must be dropped
    rst = 1'b1; up_v = 1'b1; up_pc = PA; up_t = 1'b1; up_tgt = TA; up_m = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; up_v = 1'b0; lk_pc = PA;
    @(negedge clk);
    check("rstupd hitA",  {31'b0, hit},   32'd0);
    check("rstupd tgtA",  tgt,            PA + 32'd4);
    check("rstupd bcnt",  {16'b0, bcnt},  32'd0);
    check("rstupd mcnt",  {16'b0, mcnt},  32'd0);
    lk_pc = PB;
    @(negedge clk);
    check("rstupd hitB",  {31'b0, hit},   32'd0);
    check("rstupd takenB", {31'b0, taken}, 32'd0);

    // Saturation of 4-bit statistics: 20 mispredicted updates
    check("sat init b", {28'b0, s_bcnt}, 32'd0);
    @(posedge clk); #1;
    s_up_v = 1'b1;
    for (int i = 0; i < 14; i++) @(posedge clk);
    #1;
    check("sat 14 b", {28'b0, s_bcnt}, 32'd14);
    check("sat 14 m", {28'b0, s_mcnt}, 32'd14);
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    s_up_v = 1'b0;
    check("sat 20 b", {28'b0, s_bcnt}, 32'hF);
    check("sat 20 m", {28'b0, s_mcnt}, 32'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
